// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and default sizing for the SDRAM port arbiter slice.
package sdram_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 8;
  localparam int DEF_ACK_TIMEOUT  = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_VID = 2'd1,
    ST_GRANT_CPU = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the video port, cpu port and SDRAM controller signals.
// slave is the arbiter's view; master is the surrounding system's view.
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              vid_ren;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_ack;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              timeout_err;

  modport slave (
    input  vid_ren, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_ack,
    output vid_rdata, vid_ack,
    output cpu_rdata, cpu_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output timeout_err
  );

  modport master (
    output vid_ren, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata, mem_ack,
    input  vid_rdata, vid_ack,
    input  cpu_rdata, cpu_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  timeout_err
  );

endinterface

// File: rtl/sdram_port_arbiter_timeout.sv
// Grant watchdog: cleared by load, counts while enabled, and flags the
// cycle whose rising edge would make the count reach LIMIT.
module sdram_arb_timeout
  import sdram_arb_pkg::*;
#(
  parameter int LIMIT = DEF_ACK_TIMEOUT
) (
  input  logic sdram_clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign terminal = (count == W'(LIMIT - 1));

  // Restart from zero on load, otherwise advance while enabled and not yet terminal.
  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM arbiter: video line fetch normally wins, the cpu is
// guaranteed a slot after STARVE_LIMIT back-to-back video grants, and a
// watchdog abandons grants the controller never acknowledges.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic               sdram_clk,
  input  logic               reset,
  sdram_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic          mem_ack_q;
  logic          ack_rise;
  logic          starve_full;
  logic          pick_cpu;
  logic          pick_vid;
  logic          to_load;
  logic          to_enable;
  logic          to_terminal;

  // Only a fresh rising ack counts, so a stale level left over from an
  // abandoned grant cannot complete the next one.
  assign ack_rise    = bus.mem_ack && !mem_ack_q;
  assign starve_full = (starve_cnt == SW'(STARVE_LIMIT));
  assign pick_cpu    = bus.cpu_req && (!bus.vid_ren || starve_full);
  assign pick_vid    = bus.vid_ren && !pick_cpu;
  assign to_load     = (state == ST_IDLE) && (pick_vid || pick_cpu);
  assign to_enable   = (state == ST_GRANT_VID) || (state == ST_GRANT_CPU);

  sdram_arb_timeout #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .sdram_clk (sdram_clk),
    .reset     (reset),
    .load      (to_load),
    .enable    (to_enable),
    .terminal  (to_terminal)
  );

  // Remember last cycle's controller ack for edge detection.
  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      mem_ack_q <= 1'b0;
    end else begin
      mem_ack_q <= bus.mem_ack;
    end
  end

  // Arbitration FSM, registered memory request and per-port completion.
  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      starve_cnt      <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= {ADDR_W{1'b0}};
      bus.mem_wdata   <= {DATA_W{1'b0}};
      bus.vid_rdata   <= {DATA_W{1'b0}};
      bus.cpu_rdata   <= {DATA_W{1'b0}};
      bus.vid_ack     <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vid) begin
            bus.mem_addr  <= bus.vid_addr;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_req   <= 1'b1;
            state         <= ST_GRANT_VID;
            if (!bus.cpu_req) begin
              starve_cnt <= '0;
            end else if (!starve_full) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (pick_cpu) begin
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_we    <= bus.cpu_we;
            bus.mem_wdata <= bus.cpu_wdata;
            bus.mem_req   <= 1'b1;
            state         <= ST_GRANT_CPU;
            starve_cnt    <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        ST_GRANT_VID: begin
          if (ack_rise) begin
            bus.vid_rdata <= bus.mem_rdata;
            bus.vid_ack   <= 1'b1;
            bus.mem_req   <= 1'b0;
            state         <= ST_RELEASE;
          end else if (to_terminal) begin
            bus.timeout_err <= 1'b1;
            bus.mem_req     <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        ST_GRANT_CPU: begin
          if (ack_rise) begin
            bus.cpu_rdata <= bus.mem_rdata;
            bus.cpu_ack   <= 1'b1;
            bus.mem_req   <= 1'b0;
            state         <= ST_RELEASE;
          end else if (to_terminal) begin
            bus.timeout_err <= 1'b1;
            bus.mem_req     <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          if (bus.vid_ack && !bus.vid_ren) begin
            bus.vid_ack <= 1'b0;
          end
          if (bus.cpu_ack && !bus.cpu_req) begin
            bus.cpu_ack <= 1'b0;
          end
          if (!bus.vid_ack && !bus.cpu_ack && !bus.mem_ack) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for the SDRAM port arbiter; the bench plays both the
// requesters and the SDRAM controller, all driven on falling edges.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 8;
  localparam int AT = 15;

  logic sdram_clk = 1'b0;
  logic reset;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] got_addr;
  logic [31:0] got_we;
  logic [31:0] got_wdata;
  int          hi_cycles;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (SL),
    .ACK_TIMEOUT  (AT)
  ) dut (
    .sdram_clk (sdram_clk),
    .reset     (reset),
    .bus       (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 sdram_clk = ~sdram_clk;

  // Hard stop in case something outside the bounded waits stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vr, input logic [31:0] va, input logic cr,
                               input logic cw, input logic [31:0] ca, input logic [31:0] cd);
    bus.vid_ren   = vr;
    bus.vid_addr  = va;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
  endtask

  // Wait (bounded) for the controller request and capture its fields.
  task automatic waitMemReq(input string tag, output logic [31:0] addr,
                            output logic [31:0] we, output logic [31:0] wdata);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 40) begin
      @(negedge sdram_clk);
      n++;
    end
    if (bus.mem_req !== 1'b1)
      checkOutput({tag, "_req_rise"}, 32'(bus.mem_req), 32'd1);
    addr  = 32'(bus.mem_addr);
    we    = 32'(bus.mem_we);
    wdata = 32'(bus.mem_wdata);
  endtask

  // Controller acks after delay cycles; returns once mem_req is seen low.
  task automatic ackMem(input int delay, input logic [31:0] rdata, input string tag);
    int n = 0;
    repeat (delay) @(negedge sdram_clk);
    bus.mem_rdata = rdata;
    bus.mem_ack   = 1'b1;
    @(negedge sdram_clk);
    while (bus.mem_req === 1'b1 && n < 40) begin
      @(negedge sdram_clk);
      n++;
    end
    if (bus.mem_req !== 1'b0)
      checkOutput({tag, "_req_fall"}, 32'(bus.mem_req), 32'd0);
  endtask

  // Keep mem_ack high for hold cycles, verifying the arbiter parks in RELEASE.
  task automatic releaseMem(input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge sdram_clk);
      checkOutput($sformatf("%s_hold%0d_req", tag, i), 32'(bus.mem_req), 32'd0);
      checkOutput($sformatf("%s_hold%0d_state", tag, i), 32'(dut.state), 32'(ST_RELEASE));
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge sdram_clk);

    // Reset state
    checkOutput("rst_mem_req",     32'(bus.mem_req),     32'd0);
    checkOutput("rst_mem_we",      32'(bus.mem_we),      32'd0);
    checkOutput("rst_mem_addr",    32'(bus.mem_addr),    32'd0);
    checkOutput("rst_mem_wdata",   32'(bus.mem_wdata),   32'd0);
    checkOutput("rst_vid_ack",     32'(bus.vid_ack),     32'd0);
    checkOutput("rst_cpu_ack",     32'(bus.cpu_ack),     32'd0);
    checkOutput("rst_vid_rdata",   32'(bus.vid_rdata),   32'd0);
    checkOutput("rst_cpu_rdata",   32'(bus.cpu_rdata),   32'd0);
    checkOutput("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    checkOutput("rst_state",       32'(dut.state),       32'(ST_IDLE));
    reset = 1'b0;
    @(negedge sdram_clk);

    // Video-only read, ack three cycles after the request
    $display("[TB] video-only read");
    applyStimulus(1'b1, 32'h190, 1'b0, 1'b0, 32'h0, 32'h0);
    waitMemReq("vid", got_addr, got_we, got_wdata);
    checkOutput("vid_mem_addr", got_addr, 32'h190);
    checkOutput("vid_mem_we",   got_we,   32'd0);
    ackMem(3, 32'hCAFE0001, "vid");
    checkOutput("vid_ack",      32'(bus.vid_ack),   32'd1);
    checkOutput("vid_rdata",    32'(bus.vid_rdata), 32'hCAFE0001);
    checkOutput("vid_cpu_ack",  32'(bus.cpu_ack),   32'd0);
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge sdram_clk);
    checkOutput("vid_ack_held", 32'(bus.vid_ack),   32'd1);
    bus.vid_ren = 1'b0;
    @(negedge sdram_clk);
    checkOutput("vid_ack_drop", 32'(bus.vid_ack),   32'd0);
    repeat (2) @(negedge sdram_clk);

    // Simultaneous requests: video first, then cpu write; late mem_ack release
    $display("[TB] simultaneous video and cpu write");
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    waitMemReq("sim_vid", got_addr, got_we, got_wdata);
    checkOutput("sim_vid_addr", got_addr, 32'h200);
    checkOutput("sim_vid_we",   got_we,   32'd0);
    ackMem(2, 32'h11112222, "sim_vid");
    checkOutput("sim_vid_ack",     32'(bus.vid_ack), 32'd1);
    checkOutput("sim_cpu_ack_low", 32'(bus.cpu_ack), 32'd0);
    bus.vid_ren = 1'b0;
    releaseMem(4, "late_ack");
    waitMemReq("sim_cpu", got_addr, got_we, got_wdata);
    checkOutput("sim_cpu_addr",  got_addr,  32'h10);
    checkOutput("sim_cpu_we",    got_we,    32'd1);
    checkOutput("sim_cpu_wdata", got_wdata, 32'hDEADBEEF);
    ackMem(1, 32'h33334444, "sim_cpu");
    checkOutput("sim_cpu_ack",     32'(bus.cpu_ack),   32'd1);
    checkOutput("sim_cpu_rdata",   32'(bus.cpu_rdata), 32'h33334444);
    checkOutput("sim_vid_ack_low", 32'(bus.vid_ack),   32'd0);
    checkOutput("sim_vid_rdata_hold", 32'(bus.vid_rdata), 32'h11112222);
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge sdram_clk);
    checkOutput("sim_cpu_ack_drop", 32'(bus.cpu_ack), 32'd0);
    repeat (2) @(negedge sdram_clk);

    // Starvation guard: eight video grants, then the waiting cpu, then video
    $display("[TB] starvation guard");
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int k = 0; k < SL; k++) begin
      waitMemReq("stv_vid", got_addr, got_we, got_wdata);
      checkOutput($sformatf("stv_vid%0d_addr", k), got_addr, 32'h300);
      ackMem(1, 32'(k), "stv_vid");
      bus.vid_ren = 1'b0;
      bus.mem_ack = 1'b0;
      @(negedge sdram_clk);
      bus.vid_ren = 1'b1;
    end
    waitMemReq("stv_cpu", got_addr, got_we, got_wdata);
    checkOutput("stv_cpu_addr", got_addr, 32'h44);
    checkOutput("stv_cpu_we",   got_we,   32'd0);
    ackMem(1, 32'h5555AAAA, "stv_cpu");
    checkOutput("stv_cpu_ack",     32'(bus.cpu_ack),   32'd1);
    checkOutput("stv_cpu_rdata",   32'(bus.cpu_rdata), 32'h5555AAAA);
    checkOutput("stv_vid_ack_low", 32'(bus.vid_ack),   32'd0);
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    waitMemReq("stv_resume", got_addr, got_we, got_wdata);
    checkOutput("stv_resume_addr", got_addr, 32'h300);
    ackMem(1, 32'h00000066, "stv_resume");
    checkOutput("stv_resume_ack", 32'(bus.vid_ack), 32'd1);
    bus.vid_ren = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge sdram_clk);

    // Ack timeout: request dropped after ACK_TIMEOUT cycles, no ack, retry served
    $display("[TB] ack timeout");
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0);
    waitMemReq("to", got_addr, got_we, got_wdata);
    hi_cycles = 0;
    while (bus.mem_req === 1'b1 && hi_cycles < 40) begin
      hi_cycles++;
      @(negedge sdram_clk);
    end
    checkOutput("to_req_len",     32'(hi_cycles),       32'(AT));
    checkOutput("to_err_set",     32'(bus.timeout_err), 32'd1);
    checkOutput("to_no_vid_ack",  32'(bus.vid_ack),     32'd0);
    waitMemReq("to_retry", got_addr, got_we, got_wdata);
    checkOutput("to_retry_addr", got_addr, 32'h500);
    ackMem(2, 32'h77778888, "to_retry");
    checkOutput("to_retry_ack",   32'(bus.vid_ack),   32'd1);
    checkOutput("to_retry_rdata", 32'(bus.vid_rdata), 32'h77778888);
    bus.vid_ren = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge sdram_clk);
    checkOutput("to_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset pulsed while the cpu holds the grant
    $display("[TB] reset during cpu grant");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    waitMemReq("rg", got_addr, got_we, got_wdata);
    checkOutput("rg_state_grant", 32'(dut.state), 32'(ST_GRANT_CPU));
    #2 reset = 1'b1;
    #1;
    checkOutput("rg_mem_req",     32'(bus.mem_req),     32'd0);
    checkOutput("rg_mem_addr",    32'(bus.mem_addr),    32'd0);
    checkOutput("rg_cpu_ack",     32'(bus.cpu_ack),     32'd0);
    checkOutput("rg_timeout_err", 32'(bus.timeout_err), 32'd0);
    checkOutput("rg_vid_rdata",   32'(bus.vid_rdata),   32'd0);
    checkOutput("rg_cpu_rdata",   32'(bus.cpu_rdata),   32'd0);
    checkOutput("rg_state",       32'(dut.state),       32'(ST_IDLE));
    @(negedge sdram_clk);
    reset = 1'b0;
    waitMemReq("rg_fresh", got_addr, got_we, got_wdata);
    checkOutput("rg_fresh_addr", got_addr, 32'h80);
    checkOutput("rg_fresh_we",   got_we,   32'd0);
    ackMem(2, 32'h9999AAAA, "rg_fresh");
    checkOutput("rg_fresh_ack",   32'(bus.cpu_ack),   32'd1);
    checkOutput("rg_fresh_rdata", 32'(bus.cpu_rdata), 32'h9999AAAA);
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge sdram_clk);
    checkOutput("rg_fresh_ack_drop", 32'(bus.cpu_ack), 32'd0);
    repeat (2) @(negedge sdram_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
